// File: rtl/apb_mem_pkg.sv
// Shared types and encodings for the APB-to-data-memory bridge.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/apb_strb_decode.sv
// Maps APB write strobes onto a memory access size, byte offset and right-aligned data.
module apb_strb_decode
  import apb_mem_pkg::*;
(
  input  logic [3:0]  pstrb,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] pwdata,
  output logic [1:0]  size,
  output logic [1:0]  offset,
  output logic [31:0] data,
  output logic        illegal
);

  always_comb begin
    size    = SZ_WORD;
    offset  = 2'b00;
    data    = '0;
    illegal = 1'b0;
    case (pstrb)
      4'b1111: begin
        data    = pwdata;
        illegal = (addr_lo != 2'b00);
      end
      4'b0011: begin size = SZ_HALF; data = {16'h0000, pwdata[15:0]}; end
      4'b1100: begin size = SZ_HALF; offset = 2'b10; data = {16'h0000, pwdata[31:16]}; end
      4'b0001: begin size = SZ_BYTE; data = {24'h000000, pwdata[7:0]}; end
      4'b0010: begin size = SZ_BYTE; offset = 2'b01; data = {24'h000000, pwdata[15:8]}; end
      4'b0100: begin size = SZ_BYTE; offset = 2'b10; data = {24'h000000, pwdata[23:16]}; end
      4'b1000: begin size = SZ_BYTE; offset = 2'b11; data = {24'h000000, pwdata[31:24]}; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/apb_mem_bridge.sv
// APB4 slave turning single transfers into one-cycle strobed data-memory accesses,
// with programmable read latency, address window, write protection and error counting.
module apb_mem_bridge
  import apb_mem_pkg::*;
#(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 12,
  parameter int MEM_SIZE_BYTES = 4096,
  parameter int WP_LIMIT       = 0,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                      from_top_clk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_LENGTH-1:0] from_top_apb_paddr,
  input  logic [DATA_LENGTH-1:0]    from_top_apb_pwdata,
  input  logic [DATA_LENGTH/8-1:0]  pstrb,
  output logic                      pready,
  output logic                      pslverr,
  output logic [DATA_LENGTH-1:0]    prdata,
  output logic                      to_mem_en,
  output logic                      to_mem_wr_en,
  output logic                      to_mem_rd_en,
  output logic [ADDRESS_LENGTH-1:0] to_mem_address,
  output logic [DATA_LENGTH-1:0]    to_mem_data_in,
  output logic [1:0]                to_mem_data_length,
  input  logic [DATA_LENGTH-1:0]    from_mem_data_out,
  output logic [ERR_CNT_W-1:0]      err_count
);

  localparam int               CNT_W    = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_RD_LATENCY - 1);

  if (DATA_LENGTH != 32) begin : g_bad_width
    $error("apb_mem_bridge: DATA_LENGTH must be 32");
  end
  if (MEM_RD_LATENCY < 1) begin : g_bad_latency
    $error("apb_mem_bridge: MEM_RD_LATENCY must be at least 1");
  end

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic             wr_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             setup, setup_err, rd_capture, cnt_dec;
  logic             oob_hit, wp_hit;
  logic [1:0]       dec_size, dec_offset;
  logic [31:0]      dec_data;
  logic             dec_illegal;

  apb_strb_decode u_strb_decode (
    .pstrb   (pstrb),
    .addr_lo (from_top_apb_paddr[1:0]),
    .pwdata  (from_top_apb_pwdata),
    .size    (dec_size),
    .offset  (dec_offset),
    .data    (dec_data),
    .illegal (dec_illegal)
  );

  // Range checks only exist when the window actually cuts into the address space.
  if (MEM_SIZE_BYTES < (1 << ADDRESS_LENGTH)) begin : g_oob
    assign oob_hit = 32'(from_top_apb_paddr) >= $unsigned(MEM_SIZE_BYTES);
  end else begin : g_no_oob
    assign oob_hit = 1'b0;
  end
  if (WP_LIMIT > 0) begin : g_wp
    assign wp_hit = 32'(from_top_apb_paddr) < $unsigned(WP_LIMIT);
  end else begin : g_no_wp
    assign wp_hit = 1'b0;
  end

  assign setup     = (state_q == IDLE) && psel && !penable;
  assign setup_err = oob_hit | (pwrite ? (wp_hit | dec_illegal)
                                       : (from_top_apb_paddr[1:0] != 2'b00));

  always_ff @(posedge from_top_clk) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The latency counter starts at setup and counts down from the strobe cycle on,
  // so a latency-1 read is captured at the end of ISSUE itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psel && !penable) state_d = ISSUE;
      ISSUE: begin
        if (!psel)                              state_d = IDLE;
        else if (err_q || wr_q || cnt_q == '0)  state_d = RESP;
        else                                    state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (!psel)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    to_mem_en    = 1'b0;
    to_mem_wr_en = 1'b0;
    to_mem_rd_en = 1'b0;
    pready       = 1'b0;
    pslverr      = 1'b0;
    rd_capture   = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ISSUE: if (psel && !err_q) begin
        to_mem_en    = 1'b1;
        to_mem_wr_en = wr_q;
        to_mem_rd_en = !wr_q;
        rd_capture   = !wr_q && (cnt_q == '0);
        cnt_dec      = !wr_q && (cnt_q != '0);
      end
      RD_WAIT: if (psel) begin
        rd_capture = (cnt_q == '0);
        cnt_dec    = (cnt_q != '0);
      end
      RESP: begin
        pready  = 1'b1;
        pslverr = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge from_top_clk) begin
    if (preset) begin
      wr_q               <= 1'b0;
      err_q              <= 1'b0;
      cnt_q              <= '0;
      to_mem_address     <= '0;
      to_mem_data_in     <= '0;
      to_mem_data_length <= '0;
      prdata             <= '0;
      err_count          <= '0;
    end else begin
      if (setup) begin
        wr_q               <= pwrite;
        err_q              <= setup_err;
        cnt_q              <= CNT_LOAD;
        to_mem_address     <= {from_top_apb_paddr[ADDRESS_LENGTH-1:2],
                               pwrite ? dec_offset : 2'b00};
        to_mem_data_length <= pwrite ? dec_size : SZ_WORD;
        if (pwrite) to_mem_data_in <= dec_data;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (rd_capture)         prdata    <= from_mem_data_out;
      if (pready && pslverr)  err_count <= sat_inc(err_count);
    end
  end

endmodule
